mole_controller: RTL and testbench

Game core for Whack-a-Mole: picks a pseudo-random hole, raises its mole for a fixed window, judges debounced button presses as hits or misses, and runs the round timer. It sits directly upstream of the 4-digit scoreboard. It drives the scoreboard's increment input with a single-cycle `score_inc` pulse per hit. It drives `score_clr` into the scoreboard's reset (OR'd with system reset) at round start.

---
 rtl/whack_pkg.sv | 17 +
 rtl/mole_controller_if.sv | 24 ++
 rtl/mole_controller_lfsr16.sv | 16 +
 rtl/mole_controller.sv | 159 +++++++++++++++
 tb/tb_mole_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package whack_pkg;

  localparam int unsigned N_HOLES   = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    UP,
    GAME_OVER
  } state_t;

endpackage

// File: rtl/mole_controller_if.sv
// Player-side and scoreboard-side signals of the game core.
interface mole_controller_if;
  import whack_pkg::*;

  logic               start;
  logic [N_HOLES-1:0] btn;
  logic [N_HOLES-1:0] mole;
  logic               score_inc;
  logic               score_clr;
  logic               game_over;
  logic [7:0]         miss_count;
  logic [7:0]         time_left;

  modport master (
    output start, btn,
    input  mole, score_inc, score_clr, game_over, miss_count, time_left
  );

  modport slave (
    input  start, btn,
    output mole, score_inc, score_clr, game_over, miss_count, time_left
  );

endinterface

// File: rtl/mole_controller_lfsr16.sv
// 16-bit Fibonacci LFSR, steps every cycle, seeded on reset.
module lfsr16
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Shift right, feedback into the MSB.
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {^(q & LFSR_TAPS), q[15:1]};
  end

endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole game core: hole picking, hit/miss judging, round timer.
module mole_controller
  import whack_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned MS_PER_SEC = 1000,
  parameter int unsigned UP_MS      = 800,
  parameter int unsigned GAP_MS     = 300,
  parameter int unsigned GAME_SEC   = 60
) (
  input logic              clk,
  input logic              reset,
  mole_controller_if.slave bus
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV + 1);
  localparam int unsigned PH_MAX  = (UP_MS > GAP_MS) ? UP_MS : GAP_MS;
  localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
  localparam int unsigned SEC_W   = $clog2(MS_PER_SEC + 1);

  state_t             state, next_state;
  logic [15:0]        lfsr_q;
  logic [13:0]        lfsr_unused;
  logic [1:0]         hole_raw, hole_pick, prev_hole, prev_hole_d;
  logic [PRESC_W-1:0] presc;
  logic [N_HOLES-1:0] btn_prev, btn_edge, mole_q, mole_d;
  logic               start_prev, start_edge, ms_tick;
  logic [PH_W-1:0]    phase_cnt, phase_d, phase_inc;
  logic [SEC_W-1:0]   sec_cnt, sec_d, sec_inc;
  logic [7:0]         time_left_q, time_left_d, miss_q, miss_d;
  logic               score_inc_q, score_inc_d, score_clr_q, score_clr_d, game_over_q;
  logic               in_round, hit, any_press, gap_done, up_done, sec_done, expire;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign {lfsr_unused, hole_raw} = lfsr_q;
  // Never light the same hole twice in a row.
  assign hole_pick = (hole_raw == prev_hole) ? hole_raw + 2'd1 : hole_raw;

  assign btn_edge   = bus.btn & ~btn_prev;
  assign start_edge = bus.start & ~start_prev;
  assign ms_tick    = (presc == PRESC_W'(TICK_DIV - 1));
  assign any_press  = |btn_edge;
  assign in_round   = (state == GAP) || (state == UP);
  assign hit        = (state == UP) && |(btn_edge & mole_q);
  assign phase_inc  = phase_cnt + PH_W'(1);
  assign sec_inc    = sec_cnt + SEC_W'(1);
  assign gap_done   = ms_tick && (phase_inc == PH_W'(GAP_MS));
  assign up_done    = ms_tick && (phase_inc == PH_W'(UP_MS));
  assign sec_done   = ms_tick && (sec_inc == SEC_W'(MS_PER_SEC));
  assign expire     = in_round && sec_done && (time_left_q == 8'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; restart and round expiry override the phase flow.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, GAME_OVER: if (start_edge) next_state = START;
      START:           next_state = GAP;
      GAP:             if (gap_done) next_state = UP;
      UP:              if (hit || up_done) next_state = GAP;
      default:         next_state = IDLE;
    endcase
    if (in_round) begin
      if (start_edge)  next_state = START;
      else if (expire) next_state = GAME_OVER;
    end
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    mole_d      = '0;
    score_inc_d = 1'b0;
    score_clr_d = 1'b0;
    time_left_d = time_left_q;
    miss_d      = miss_q;
    phase_d     = phase_cnt;
    sec_d       = sec_cnt;
    prev_hole_d = prev_hole;
    if (next_state == START) begin
      score_clr_d = 1'b1;
      time_left_d = 8'(GAME_SEC);
      miss_d      = '0;
      phase_d     = '0;
      sec_d       = '0;
    end else begin
      if (in_round) begin
        if (ms_tick) begin
          phase_d = phase_inc;
          if (sec_done) begin
            sec_d       = '0;
            time_left_d = time_left_q - 8'd1;
          end else begin
            sec_d = sec_inc;
          end
        end
        if (hit)                              score_inc_d = 1'b1;
        else if (any_press && miss_q != 8'hFF) miss_d     = miss_q + 8'd1;
      end
      if (next_state != state) phase_d = '0;
      if (next_state == UP) begin
        if (state == UP) begin
          mole_d = mole_q;
        end else begin
          prev_hole_d = hole_pick;
          for (int i = 0; i < int'(N_HOLES); i++) mole_d[i] = (2'(i) == hole_pick);
        end
      end
    end
  end

  // Output, counter and edge-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc       <= '0;
      btn_prev    <= '0;
      start_prev  <= 1'b0;
      prev_hole   <= '0;
      phase_cnt   <= '0;
      sec_cnt     <= '0;
      mole_q      <= '0;
      score_inc_q <= 1'b0;
      score_clr_q <= 1'b0;
      game_over_q <= 1'b0;
      time_left_q <= '0;
      miss_q      <= '0;
    end else begin
      presc       <= ms_tick ? '0 : presc + PRESC_W'(1);
      btn_prev    <= bus.btn;
      start_prev  <= bus.start;
      prev_hole   <= prev_hole_d;
      phase_cnt   <= phase_d;
      sec_cnt     <= sec_d;
      mole_q      <= mole_d;
      score_inc_q <= score_inc_d;
      score_clr_q <= score_clr_d;
      game_over_q <= (next_state == GAME_OVER);
      time_left_q <= time_left_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.mole       = mole_q;
  assign bus.score_inc  = score_inc_q;
  assign bus.score_clr  = score_clr_q;
  assign bus.game_over  = game_over_q;
  assign bus.miss_count = miss_q;
  assign bus.time_left  = time_left_q;

endmodule

// File: tb/tb_mole_controller.sv
// Self-checking bench for mole_controller against a tick-count reference model.
module tb_mole_controller;
  import whack_pkg::*;

  localparam int unsigned TD = 4, MPS = 10, UPM = 5, GAPM = 3, GS = 2;
  localparam int ROUND_TICKS = GS * MPS;
  localparam int M_IDLE = 0, M_START = 1, M_GAP = 2, M_UP = 3, M_OVER = 4;

  logic clk;
  logic reset;
  mole_controller_if bus ();

  mole_controller #(
    .TICK_DIV(TD), .MS_PER_SEC(MPS), .UP_MS(UPM), .GAP_MS(GAPM), .GAME_SEC(GS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time is measured in absolute tick counts, not counters.
  int          m_mode, m_cyc, m_rticks, m_pticks, m_prev_hole, m_miss, m_tl;
  logic [15:0] m_lfsr;
  logic [3:0]  m_mole, m_bprev;
  logic        m_sprev, m_inc, m_clr;

  int   n_vec = 0, n_err = 0, inc_seen = 0;
  logic cur_start = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic enter_start();
    m_mode = M_START; m_clr = 1'b1; m_tl = GS; m_miss = 0;
    m_rticks = 0; m_pticks = 0; m_mole = 4'h0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic s, input logic r);
    logic [3:0] bedge;
    logic       sedge, tick, is_hit, expired;
    int         h, lbit;
    if (r) begin
      m_mode = M_IDLE; m_cyc = 0; m_lfsr = 16'hACE1; m_mole = 4'h0;
      m_bprev = 4'h0; m_sprev = 1'b0; m_inc = 1'b0; m_clr = 1'b0;
      m_miss = 0; m_tl = 0; m_prev_hole = 0; m_rticks = 0; m_pticks = 0;
      return;
    end
    bedge = b & ~m_bprev;
    sedge = s & ~m_sprev;
    tick  = ((m_cyc % TD) == TD - 1);
    m_inc = 1'b0;
    m_clr = 1'b0;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (sedge) enter_start();
    end else if (m_mode == M_START) begin
      m_mode = M_GAP; m_pticks = 0;
    end else if (sedge) begin
      enter_start();
    end else begin
      if (tick) begin m_rticks++; m_pticks++; end
      expired = tick && (m_rticks == ROUND_TICKS);
      m_tl    = GS - m_rticks / MPS;
      is_hit  = (m_mode == M_UP) && ((bedge & m_mole) != 4'h0);
      if (is_hit)               m_inc = 1'b1;
      else if (bedge != 4'h0)   m_miss = (m_miss < 255) ? m_miss + 1 : 255;
      if (expired) begin
        m_mode = M_OVER; m_mole = 4'h0;
      end else if (is_hit || (m_mode == M_UP && m_pticks == UPM)) begin
        m_mode = M_GAP; m_mole = 4'h0; m_pticks = 0;
      end else if (m_mode == M_GAP && m_pticks == GAPM) begin
        h = int'(m_lfsr) % 4;
        if (h == m_prev_hole) h = (h + 1) % 4;
        m_prev_hole = h;
        m_mole = 4'(1 << h);
        m_mode = M_UP; m_pticks = 0;
      end
    end
    m_bprev = b;
    m_sprev = s;
    lbit   = (int'(m_lfsr) ^ (int'(m_lfsr) >> 2) ^ (int'(m_lfsr) >> 3) ^ (int'(m_lfsr) >> 5)) & 1;
    m_lfsr = 16'((int'(m_lfsr) >> 1) | (lbit << 15));
    m_cyc++;
  endtask

  task automatic step(input logic [3:0] b, input logic s, input logic r);
    bus.btn = b; bus.start = s; reset = r;
    @(posedge clk);
    model_edge(b, s, r);
    @(negedge clk);
    inc_seen += int'(bus.score_inc);
    chk("mole",       int'(bus.mole),       int'(m_mole));
    chk("score_inc",  int'(bus.score_inc),  int'(m_inc));
    chk("score_clr",  int'(bus.score_clr),  int'(m_clr));
    chk("game_over",  int'(bus.game_over),  int'(m_mode == M_OVER));
    chk("miss_count", int'(bus.miss_count), m_miss);
    chk("time_left",  int'(bus.time_left),  m_tl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, cur_start, 1'b0);
  endtask

  task automatic wait_mode(input int target, input int budget);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin
      step(4'h0, cur_start, 1'b0);
      n++;
    end
    chk($sformatf("reach_mode_%0d", target), int'(n < budget), 1);
  endtask

  task automatic start_round();
    cur_start = 1'b0; step(4'h0, cur_start, 1'b0);
    cur_start = 1'b1; step(4'h0, cur_start, 1'b0);
  endtask

  initial begin
    logic [3:0] hole1, b;
    logic       did_press;
    int         n;
    bus.btn = 4'h0; bus.start = 1'b0; reset = 1'b1;

    // Reset, then a long idle with no start.
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b1);
    inc_seen = 0;
    idle(200);
    chk("idle_no_pulse", inc_seen, 0);

    // Start edge: clear pulse, timer load, first mole after GAP_MS ticks.
    start_round();
    chk("start_clr", int'(bus.score_clr), 1);
    chk("start_time", int'(bus.time_left), GS);
    wait_mode(M_UP, 40);

    // Hit the lit hole and hold it.
    hole1 = bus.mole;
    inc_seen = 0;
    for (int i = 0; i < 3; i++) step(hole1, cur_start, 1'b0);
    step(4'h0, cur_start, 1'b0);
    chk("hit_pulses", inc_seen, 1);
    chk("hit_no_miss", int'(bus.miss_count), 0);
    wait_mode(M_UP, 40);
    chk("next_hole_differs", int'(bus.mole != hole1), 1);

    // Unlit press in UP, single press in GAP, triple press in GAP.
    b = (m_mole == 4'h1) ? 4'h2 : 4'h1;
    step(b, cur_start, 1'b0);
    step(4'h0, cur_start, 1'b0);
    wait_mode(M_GAP, 40);
    step(4'h1, cur_start, 1'b0);
    step(4'h0, cur_start, 1'b0);
    step(4'h7, cur_start, 1'b0);
    step(4'h0, cur_start, 1'b0);
    chk("miss_three", int'(bus.miss_count), 3);
    wait_mode(M_UP, 40);
    b = m_mole | ((m_mole == 4'h8) ? 4'h1 : 4'h8);
    step(b, cur_start, 1'b0);
    chk("lit_plus_unlit_hit", int'(bus.score_inc), 1);
    chk("lit_plus_unlit_nomiss", int'(bus.miss_count), 3);
    step(4'h0, cur_start, 1'b0);

    // Idle out the round; presses after game over are ignored.
    wait_mode(M_OVER, 200);
    chk("over_flag", int'(bus.game_over), 1);
    chk("over_time", int'(bus.time_left), 0);
    step(4'h5, cur_start, 1'b0);
    step(4'h0, cur_start, 1'b0);
    chk("over_miss_hold", int'(bus.miss_count), 3);

    // Hit landing on the expiry cycle.
    start_round();
    inc_seen = 0;
    did_press = 1'b0;
    n = 0;
    while (m_mode != M_OVER && n < 200) begin
      if ((m_mode == M_UP) && ((m_cyc % TD) == TD - 1) && (m_rticks + 1 == ROUND_TICKS)) begin
        step(m_mole, cur_start, 1'b0);
        did_press = 1'b1;
        chk("expiry_hit_inc", int'(bus.score_inc), 1);
        chk("expiry_hit_over", int'(bus.game_over), 1);
      end else begin
        step(4'h0, cur_start, 1'b0);
      end
      n++;
    end
    chk("expiry_pressed", int'(did_press), 1);
    step(4'h0, cur_start, 1'b0);
    chk("expiry_pulses", inc_seen, 1);

    // Reset mid-round.
    start_round();
    idle(20);
    step(4'h0, cur_start, 1'b1);
    chk("rst_clr", int'(bus.score_clr), 0);
    chk("rst_time", int'(bus.time_left), 0);
    chk("rst_mole", int'(bus.mole), 0);
    step(4'h0, cur_start, 1'b0);

    // Randomized play, with occasional restarts and resets.
    b = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 4'($urandom);
        1:       b = m_mole;
        2, 3:    b = 4'h0;
        default: ;
      endcase
      if ($urandom_range(0, 119) == 0) cur_start = ~cur_start;
      step(b, cur_start, ($urandom_range(0, 599) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
